// File: rtl/snitch_icache_data_ctrl.sv
// Instruction-cache data SRAM controller: arbitrates refill writes and lookup
// reads onto the shared per-set SRAM port and queues read data in a 2-deep FIFO.
module snitch_icache_data_ctrl #(
   parameter int unsigned SET_COUNT       = 2,
   parameter int unsigned LINE_COUNT      = 128,
   parameter int unsigned LINE_WIDTH      = 256,
   parameter int unsigned MAX_WRITE_BURST = 4,
   parameter int unsigned COUNT_ALIGN     = $clog2(LINE_COUNT),
   parameter int unsigned SET_ALIGN       = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 write_valid_i,
   output logic                                 write_ready_o,
   input  logic [SET_ALIGN-1:0]                 write_set_i,
   input  logic [COUNT_ALIGN-1:0]               write_addr_i,
   input  logic [LINE_WIDTH-1:0]                write_data_i,
   input  logic                                 lookup_valid_i,
   output logic                                 lookup_ready_o,
   input  logic [SET_ALIGN-1:0]                 lookup_set_i,
   input  logic [COUNT_ALIGN-1:0]               lookup_addr_i,
   output logic                                 rsp_valid_o,
   input  logic                                 rsp_ready_i,
   output logic [LINE_WIDTH-1:0]                rsp_data_o,
   output logic [SET_COUNT-1:0]                 ram_enable_o,
   output logic                                 ram_write_o,
   output logic [COUNT_ALIGN-1:0]               ram_addr_o,
   output logic [SET_COUNT-1:0][LINE_WIDTH-1:0] ram_wdata_o,
   input  logic [SET_COUNT-1:0][LINE_WIDTH-1:0] ram_rdata_i
);

   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = 2;
   localparam int unsigned SET_CMP_W  = SET_ALIGN + 1;
   localparam int unsigned STARVE_W   = $clog2(MAX_WRITE_BURST + 1);

   // Response FIFO and read-tracking state
   logic [LINE_WIDTH-1:0] fifo_q [FIFO_DEPTH];
   logic                  rd_ptr_q;
   logic                  wr_ptr_q;
   logic [CNT_W-1:0]      fifo_count_q;
   logic                  inflight_q;
   logic [SET_ALIGN-1:0]  set_q;
   logic [STARVE_W-1:0]   starve_cnt_q;

   logic                  write_set_ok_c;
   logic                  lookup_set_ok_c;
   logic                  write_req_c;
   logic                  lookup_req_c;
   logic                  starve_full_c;
   logic                  push_c;
   logic                  pop_c;
   logic                  read_ok_c;
   logic [CNT_W-1:0]      occupancy_c;
   logic                  write_gnt_c;
   logic                  lookup_gnt_c;

   // Out-of-range sets never reach the SRAM; widened compare keeps it meaningful
   assign write_set_ok_c  = SET_CMP_W'(write_set_i)  < SET_CMP_W'(SET_COUNT);
   assign lookup_set_ok_c = SET_CMP_W'(lookup_set_i) < SET_CMP_W'(SET_COUNT);
   assign write_req_c     = write_valid_i  && write_set_ok_c  && !rst_i;
   assign lookup_req_c    = lookup_valid_i && lookup_set_ok_c && !rst_i;

   assign starve_full_c = (starve_cnt_q == STARVE_W'(MAX_WRITE_BURST));

   assign rsp_valid_o = (fifo_count_q != '0);
   assign rsp_data_o  = fifo_q[rd_ptr_q];
   assign pop_c       = rsp_valid_o && rsp_ready_i;
   assign push_c      = inflight_q;

   // A new read needs a free slot counting the read already in the SRAM pipe
   assign occupancy_c = fifo_count_q + CNT_W'(inflight_q);
   assign read_ok_c   = (occupancy_c < CNT_W'(FIFO_DEPTH)) ||
                        ((occupancy_c == CNT_W'(FIFO_DEPTH)) && pop_c);

   // Writes win unless a lookup has waited out a full write burst
   always_comb begin
      lookup_gnt_c = 1'b0;
      write_gnt_c  = 1'b0;
      if (lookup_req_c && read_ok_c && (!write_req_c || starve_full_c)) begin
         lookup_gnt_c = 1'b1;
      end else if (write_req_c) begin
         write_gnt_c = 1'b1;
      end
   end

   assign write_ready_o  = write_gnt_c;
   assign lookup_ready_o = lookup_gnt_c;

   // Shared SRAM port
   always_comb begin
      ram_enable_o = '0;
      ram_write_o  = 1'b0;
      ram_addr_o   = '0;
      if (write_gnt_c) begin
         ram_enable_o[write_set_i] = 1'b1;
         ram_write_o               = 1'b1;
         ram_addr_o                = write_addr_i;
      end else if (lookup_gnt_c) begin
         ram_enable_o[lookup_set_i] = 1'b1;
         ram_addr_o                 = lookup_addr_i;
      end
   end

   assign ram_wdata_o = {SET_COUNT{write_data_i}};

   // Count write grants that bypass a waiting lookup
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt_q <= '0;
      end else if (lookup_gnt_c || !lookup_valid_i) begin
         starve_cnt_q <= '0;
      end else if (write_gnt_c && !starve_full_c) begin
         starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         inflight_q <= 1'b0;
         set_q      <= '0;
      end else begin
         inflight_q <= lookup_gnt_c;
         if (lookup_gnt_c) begin
            set_q <= lookup_set_i;
         end
      end
   end

   // Two-entry ring; pointer toggles suffice for depth two
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         fifo_count_q <= '0;
      end else begin
         if (push_c) begin
            fifo_q[wr_ptr_q] <= ram_rdata_i[set_q];
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_c) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         fifo_count_q <= fifo_count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_c && !pop_c && (fifo_count_q == CNT_W'(FIFO_DEPTH))));

   a_write_set_range: assert property (@(posedge clk_i) disable iff (rst_i)
      write_valid_i |-> write_set_ok_c);

   a_lookup_set_range: assert property (@(posedge clk_i) disable iff (rst_i)
      lookup_valid_i |-> lookup_set_ok_c);

   a_enable_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(ram_enable_o));

   a_single_grant: assert property (@(posedge clk_i) disable iff (rst_i)
      !(write_gnt_c && lookup_gnt_c));

endmodule

// File: doc/snitch_icache_data_ctrl.md
# snitch_icache_data_ctrl

- Sits between the instruction-cache lookup/refill logic and the per-set data SRAM array.
- Arbitrates single-line refill writes and lookup reads onto the shared SRAM port: one-hot set enable, common write strobe, common address, per-set write data.
- Captures the 1-cycle-latency read data of the selected set into a 2-entry response FIFO with valid/ready handshake.
- Guarantees lookup progress under sustained refill traffic.

## Interface
- SET_COUNT, 2, number of cache ways (data SRAM sets)
- LINE_COUNT, 128, lines per set
- LINE_WIDTH, 256, bits per line
- MAX_WRITE_BURST, 4, consecutive write grants allowed while a lookup waits (>=1)
- COUNT_ALIGN, $clog2(LINE_COUNT), line-index width (derived)
- SET_ALIGN, $clog2(SET_COUNT) (min 1), set-index width (derived)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- write_valid_i  in  1  refill write request
- write_ready_o  out  1  write granted this cycle
- write_set_i  in  SET_ALIGN  target set
- write_addr_i  in  COUNT_ALIGN  target line
- write_data_i  in  LINE_WIDTH  line data
- lookup_valid_i  in  1  read request
- lookup_ready_o  out  1  read granted this cycle
- lookup_set_i  in  SET_ALIGN  set to read
- lookup_addr_i  in  COUNT_ALIGN  line to read
- rsp_valid_o  out  1  response FIFO head valid
- rsp_ready_i  in  1  consumer accepts head
- rsp_data_o  out  LINE_WIDTH  head line data
- ram_enable_o  out  SET_COUNT  one-hot SRAM request
- ram_write_o  out  1  1 = write, 0 = read
- ram_addr_o  out  COUNT_ALIGN  SRAM line address
- ram_wdata_o  out  SET_COUNT x LINE_WIDTH  write_data_i replicated to every set
- ram_rdata_i  in  SET_COUNT x LINE_WIDTH  SRAM read data, valid 1 cycle after read request

## Operation
- Per cycle at most one SRAM access. ram_enable_o is all-zero when idle, otherwise exactly one bit set.
- Read capacity:
  - read_ok = (fifo_count + inflight < 2) or (fifo_count + inflight == 2 and rsp_valid_o and rsp_ready_i).
  - inflight is 1 in the cycle after a read grant, otherwise 0.
- Arbitration, combinational each cycle:
  - Only write pending: write granted.
  - Only lookup pending: lookup granted if read_ok.
  - Both pending: write wins unless starve_cnt == MAX_WRITE_BURST and read_ok. In that case lookup wins.
- starve_cnt:
  - Increments on each write grant while lookup_valid_i is high and the lookup is not granted; saturates at MAX_WRITE_BURST.
  - Clears on lookup grant or when lookup_valid_i is low.
- Write grant: write_ready_o=1, ram_write_o=1, ram_enable_o[write_set_i]=1, ram_addr_o=write_addr_i.
- Read grant: lookup_ready_o=1, ram_write_o=0, ram_enable_o[lookup_set_i]=1, ram_addr_o=lookup_addr_i. The set index is registered with inflight.
- Capture: when inflight=1, ram_rdata_i[set_q] is pushed into the FIFO at that cycle's clock edge.
- Response FIFO:
  - 2 entries, in-order.
  - Push and pop in the same cycle are legal.
  - Overflow cannot occur by construction; an assertion checks it.
- Write/read ordering is strictly SRAM order. A write granted in cycle t is visible to a read granted in cycle t+1 or later.
- ready outputs are combinational from valid, FIFO state and starve_cnt. They never depend on the ready of the same request.
- Out-of-range set index (>= SET_COUNT): no enable asserted and no grant; assertion fires.

## Timing
- Reset values: fifo_count=0, inflight=0, starve_cnt=0, rsp_valid_o=0, rsp_data_o=0, ram_enable_o=0, ram_write_o=0, write_ready_o=0, lookup_ready_o=0.
- Read latency: lookup granted in cycle t, SRAM read in t, data on ram_rdata_i in t+1, pushed at end of t+1, rsp_valid_o=1 in t+2.
- Throughput is 1 read per cycle with rsp_ready_i held high and no writes.
- Write latency: granted in cycle t, SRAM written at end of t. No response is produced.
- Backpressure: with rsp_ready_i low, at most 2 lookups are accepted; lookup_ready_o stays 0 until a pop.
- Reset mid-operation: the in-flight read is discarded, the FIFO is emptied and starve_cnt is cleared asynchronously. The SRAM contents are not touched.

## Test plan
- Single read: write line 5 of set 1 = 0xA5 pattern; cycle t lookup set 1/line 5 -> ram_enable_o=2'b10, ram_write_o=0 in t; rsp_valid_o=1 with 0xA5 pattern in t+2.
- Streaming: 16 back-to-back lookups, rsp_ready_i=1 -> lookup_ready_o high every cycle, 16 in-order responses on consecutive cycles starting 2 cycles after the first grant.
- Backpressure: rsp_ready_i=0, lookup_valid_i=1 continuously -> exactly 2 grants, then lookup_ready_o=0; raise rsp_ready_i -> one grant per pop, no data lost or reordered.
- Starvation guard: MAX_WRITE_BURST=4, write_valid_i and lookup_valid_i both held high -> grant pattern W,W,W,W,R repeating.
- Write-then-read same line: write in cycle t, read of the same set/line in t+1 -> response equals the new data.
- Async reset with one read in flight and 1 FIFO entry -> rsp_valid_o=0 immediately; after release, the next lookup has normal 2-cycle latency and no stale response appears.
